// File: rtl/r5fp_idiv_sqrt_arbiter_pkg.sv
// Shared types for the divide/sqrt engine arbiter.
// Channel 0 is the FP divide front-end, channel 1 the FP sqrt front-end.
package r5fp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_e;

   localparam logic CH_DIV  = 1'b0;
   localparam logic CH_SQRT = 1'b1;

endpackage

// File: rtl/r5fp_idiv_sqrt_arbiter_if.sv
// Signal bundle between the two FP front-ends, the shared engine
// and the arbiter; slave is the arbiter side, master the environment.
interface r5fp_idiv_sqrt_arbiter_if #(
   parameter int W = 26
);

   logic         div_strobe_i;
   logic [W-1:0] div_N_i;
   logic [W-1:0] div_D_i;
   logic [W-1:0] div_Quo_o;
   logic [W-1:0] div_Rem_o;
   logic         div_done_o;
   logic         div_ready_o;

   logic         sqrt_strobe_i;
   logic [W-1:0] sqrt_N_i;
   logic [W-1:0] sqrt_D_i;
   logic [W-1:0] sqrt_Quo_o;
   logic [W-1:0] sqrt_Rem_o;
   logic         sqrt_done_o;
   logic         sqrt_ready_o;

   logic [W-1:0] eng_N_o;
   logic [W-1:0] eng_D_o;
   logic         eng_strobe_o;
   logic         eng_is_div_o;
   logic [W-1:0] eng_Quo_i;
   logic [W-1:0] eng_Rem_i;
   logic         eng_done_i;
   logic         eng_ready_i;

   logic         busy_o;

   modport slave (
      input  div_strobe_i, div_N_i, div_D_i,
      output div_Quo_o, div_Rem_o, div_done_o, div_ready_o,
      input  sqrt_strobe_i, sqrt_N_i, sqrt_D_i,
      output sqrt_Quo_o, sqrt_Rem_o, sqrt_done_o, sqrt_ready_o,
      output eng_N_o, eng_D_o, eng_strobe_o, eng_is_div_o,
      input  eng_Quo_i, eng_Rem_i, eng_done_i, eng_ready_i,
      output busy_o
   );

   modport master (
      output div_strobe_i, div_N_i, div_D_i,
      input  div_Quo_o, div_Rem_o, div_done_o, div_ready_o,
      output sqrt_strobe_i, sqrt_N_i, sqrt_D_i,
      input  sqrt_Quo_o, sqrt_Rem_o, sqrt_done_o, sqrt_ready_o,
      input  eng_N_o, eng_D_o, eng_strobe_o, eng_is_div_o,
      output eng_Quo_i, eng_Rem_i, eng_done_i, eng_ready_i,
      input  busy_o
   );

endinterface

// File: rtl/r5fp_idiv_sqrt_arbiter.sv
// Round-robin sharing of one iterative div/sqrt engine between the
// FP divide and FP sqrt front-ends; each sees a private engine.
module r5fp_idiv_sqrt_arbiter
   import r5fp_arb_pkg::*;
#(
   parameter int W = 26
) (
   input logic                    clk,
   input logic                    reset,
   r5fp_idiv_sqrt_arbiter_if.slave bus
);

   state_e state_q, state_d;

   logic grant_q, grant_d;
   logic last_q, last_d;

   logic [1:0] pend_q, pend_d;
   logic [1:0] done_q, done_d;

   logic [1:0][W-1:0] opn_q, opn_d;
   logic [1:0][W-1:0] opd_q, opd_d;
   logic [1:0][W-1:0] quo_q, quo_d;
   logic [1:0][W-1:0] rem_q, rem_d;

   logic [W-1:0] eng_n_q, eng_n_d;
   logic [W-1:0] eng_d_q, eng_d_d;
   logic         eng_div_q, eng_div_d;

   logic [1:0]        strb;
   logic [1:0][W-1:0] in_n;
   logic [1:0][W-1:0] in_d;
   logic              pick;

   assign strb = {bus.sqrt_strobe_i, bus.div_strobe_i};
   assign in_n = {bus.sqrt_N_i, bus.div_N_i};
   assign in_d = {bus.sqrt_D_i, bus.div_D_i};

   // On a tie the channel that did not win last time goes next.
   always_comb begin
      pick = CH_DIV;
      if (&pend_q) begin
         pick = ~last_q;
      end else if (pend_q[CH_SQRT]) begin
         pick = CH_SQRT;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      pend_d    = pend_q;
      done_d    = '0;
      opn_d     = opn_q;
      opd_d     = opd_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      eng_n_d   = eng_n_q;
      eng_d_d   = eng_d_q;
      eng_div_d = eng_div_q;

      for (int c = 0; c < 2; c++) begin
         if (strb[c] && !pend_q[c]) begin
            pend_d[c] = 1'b1;
            opn_d[c]  = in_n[c];
            opd_d[c]  = in_d[c];
         end
      end

      unique case (state_q)
         IDLE: begin
            if ((|pend_q) && bus.eng_ready_i) begin
               grant_d   = pick;
               last_d    = pick;
               eng_n_d   = opn_q[pick];
               eng_d_d   = opd_q[pick];
               eng_div_d = (pick == CH_DIV);
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.eng_done_i) begin
               quo_d[grant_q]  = bus.eng_Quo_i;
               rem_d[grant_q]  = bus.eng_Rem_i;
               pend_d[grant_q] = 1'b0;
               done_d[grant_q] = 1'b1;
               state_d         = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= CH_DIV;
         last_q    <= CH_SQRT;
         pend_q    <= '0;
         done_q    <= '0;
         opn_q     <= '0;
         opd_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         eng_n_q   <= '0;
         eng_d_q   <= '0;
         eng_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
         opn_q     <= opn_d;
         opd_q     <= opd_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         eng_n_q   <= eng_n_d;
         eng_d_q   <= eng_d_d;
         eng_div_q <= eng_div_d;
      end
   end

   assign bus.div_Quo_o    = quo_q[CH_DIV];
   assign bus.div_Rem_o    = rem_q[CH_DIV];
   assign bus.div_done_o   = done_q[CH_DIV];
   assign bus.div_ready_o  = !pend_q[CH_DIV];

   assign bus.sqrt_Quo_o   = quo_q[CH_SQRT];
   assign bus.sqrt_Rem_o   = rem_q[CH_SQRT];
   assign bus.sqrt_done_o  = done_q[CH_SQRT];
   assign bus.sqrt_ready_o = !pend_q[CH_SQRT];

   assign bus.eng_N_o      = eng_n_q;
   assign bus.eng_D_o      = eng_d_q;
   assign bus.eng_is_div_o = eng_div_q;
   assign bus.eng_strobe_o = (state_q == ISSUE);
   assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_r5fp_idiv_sqrt_arbiter.sv
// Directed bench for the div/sqrt engine arbiter with a behavioural
// fixed-latency engine standing in for the shared divider.
module tb_r5fp_idiv_sqrt_arbiter;
   import r5fp_arb_pkg::*;

   localparam int W   = 26;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   r5fp_idiv_sqrt_arbiter_if #(.W(W)) bus ();

   r5fp_idiv_sqrt_arbiter #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic         ch;
      logic [W-1:0] n;
      logic [W-1:0] d;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   int tests = 0;
   int fails = 0;

   // Engine: div gives (N<<23)/D, sqrt gives isqrt(N<<22), W-bit truncated.
   logic         eng_en = 1'b1;
   logic         spur = 1'b0;
   logic         eng_busy;
   logic         eng_done_q;
   int           eng_cnt;
   logic         eng_div;
   logic [W-1:0] eng_n, eng_d, eq, er;

   function automatic logic [2*W-1:0] model(logic is_div, logic [W-1:0] n,
                                             logic [W-1:0] d);
      logic [63:0] x, q, r, t;
      if (is_div) begin
         x = {38'd0, n} << 23;
         q = (d == 0) ? 64'd0 : x / {38'd0, d};
         r = (d == 0) ? 64'd0 : x % {38'd0, d};
      end else begin
         x = {38'd0, n} << 22;
         q = 64'd0;
         for (int b = 24; b >= 0; b--) begin
            t = q | (64'd1 << b);
            if (t * t <= x) q = t;
         end
         r = x - q * q;
      end
      return {q[W-1:0], r[W-1:0]};
   endfunction

   assign bus.eng_ready_i = !eng_busy && eng_en;
   assign bus.eng_done_i  = eng_done_q | spur;
   assign bus.eng_Quo_i   = eq;
   assign bus.eng_Rem_i   = er;

   always @(posedge clk) begin
      eng_done_q <= 1'b0;
      if (reset) begin
         eng_busy <= 1'b0;
         eng_cnt  <= 0;
         eq       <= '0;
         er       <= '0;
      end else if (eng_busy) begin
         if (eng_cnt == 1) begin
            eng_busy   <= 1'b0;
            eng_done_q <= 1'b1;
            {eq, er}   <= model(eng_div, eng_n, eng_d);
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end else if (bus.eng_strobe_o) begin
         eng_busy <= 1'b1;
         eng_cnt  <= LAT;
         eng_div  <= bus.eng_is_div_o;
         eng_n    <= bus.eng_N_o;
         eng_d    <= bus.eng_D_o;
      end
   end

   int div_dones = 0;
   int sqrt_dones = 0;
   int eng_strobes = 0;
   bit gseq[$];

   always @(posedge clk) begin
      if (bus.div_done_o) div_dones++;
      if (bus.sqrt_done_o) sqrt_dones++;
      if (bus.eng_strobe_o) begin
         eng_strobes++;
         gseq.push_back(bus.eng_is_div_o);
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic ch, logic v, logic [W-1:0] n, logic [W-1:0] d);
      if (ch == CH_DIV) begin
         bus.div_strobe_i = v;
         bus.div_N_i      = n;
         bus.div_D_i      = d;
      end else begin
         bus.sqrt_strobe_i = v;
         bus.sqrt_N_i      = n;
         bus.sqrt_D_i      = d;
      end
   endtask

   function automatic logic done_of(logic ch);
      return (ch == CH_DIV) ? bus.div_done_o : bus.sqrt_done_o;
   endfunction

   function automatic logic ready_of(logic ch);
      return (ch == CH_DIV) ? bus.div_ready_o : bus.sqrt_ready_o;
   endfunction

   function automatic logic [W-1:0] quo_of(logic ch);
      return (ch == CH_DIV) ? bus.div_Quo_o : bus.sqrt_Quo_o;
   endfunction

   function automatic logic [W-1:0] rem_of(logic ch);
      return (ch == CH_DIV) ? bus.div_Rem_o : bus.sqrt_Rem_o;
   endfunction

   function automatic int dones_of(logic ch);
      return (ch == CH_DIV) ? div_dones : sqrt_dones;
   endfunction

   task automatic wait_done(logic ch, string nm, output int n);
      bit seen;
      n    = 0;
      seen = 0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         seen = done_of(ch);
      end
      chk({nm, " done seen"}, seen, 1);
   endtask

   task automatic run_vec(vec_t v, string nm);
      logic [W-1:0] oq, orr;
      int od, n;
      oq  = quo_of(~v.ch);
      orr = rem_of(~v.ch);
      od  = dones_of(~v.ch);
      @(negedge clk);
      drive(v.ch, 1'b1, v.n, v.d);
      @(negedge clk);
      drive(v.ch, 1'b0, '0, '0);
      chk({nm, " ready low"}, ready_of(v.ch), 0);
      @(negedge clk);
      chk({nm, " eng strobe"}, bus.eng_strobe_o, 1);
      chk({nm, " is_div"}, bus.eng_is_div_o, v.ch == CH_DIV);
      chk({nm, " eng N/D"}, {bus.eng_N_o, bus.eng_D_o}, {v.n, v.d});
      wait_done(v.ch, nm, n);
      chk({nm, " latency"}, n, 6);
      chk({nm, " Quo"}, quo_of(v.ch), v.q);
      chk({nm, " Rem"}, rem_of(v.ch), v.r);
      chk({nm, " ready back"}, ready_of(v.ch), 1);
      chk({nm, " other res"}, {quo_of(~v.ch), rem_of(~v.ch)}, {oq, orr});
      chk({nm, " other done"}, dones_of(~v.ch), od);
      @(negedge clk);
      chk({nm, " done pulse"}, done_of(v.ch), 0);
   endtask

   vec_t tbl[8];

   initial begin
      int n, dd, sd, nd, ns, viol, bad, snap, s0;

      tbl[0] = '{CH_DIV,  26'h1000000, 26'h0800000, 26'h1000000, 26'h0};
      tbl[1] = '{CH_SQRT, 26'h1000000, 26'h0,       26'h0800000, 26'h0};
      tbl[2] = '{CH_DIV,  26'h0C00000, 26'h0800000, 26'h0C00000, 26'h0};
      tbl[3] = '{CH_DIV,  26'h0000001, 26'h0000003, 26'h02AAAAA, 26'h2};
      tbl[4] = '{CH_SQRT, 26'h0900000, 26'h0,       26'h0600000, 26'h0};
      tbl[5] = '{CH_SQRT, 26'h0000002, 26'h0,       26'h0000B50, 26'h700};
      tbl[6] = '{CH_DIV,  26'h3FFFFFF, 26'h3FFFFFF, 26'h0800000, 26'h0};
      tbl[7] = '{CH_DIV,  26'h3FFFFFF, 26'h0000001, 26'h3800000, 26'h0};

      drive(CH_DIV, 1'b0, '0, '0);
      drive(CH_SQRT, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst results", {bus.div_Quo_o, bus.div_Rem_o,
                          bus.sqrt_Quo_o, bus.sqrt_Rem_o}, 0);
      chk("rst eng ops", {bus.eng_N_o, bus.eng_D_o}, 0);
      chk("rst ctl", {bus.eng_strobe_o, bus.eng_is_div_o, bus.div_done_o,
                      bus.sqrt_done_o, bus.busy_o}, 0);
      chk("rst ready", {bus.div_ready_o, bus.sqrt_ready_o}, 2'b11);

      for (int i = 0; i < 8; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Simultaneous requests after reset: div wins the first tie.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive(CH_DIV, 1'b1, 26'h1, 26'h3);
      drive(CH_SQRT, 1'b1, 26'h2, 26'h0);
      @(negedge clk);
      drive(CH_DIV, 1'b0, '0, '0);
      drive(CH_SQRT, 1'b0, '0, '0);
      chk("tie both pend", {bus.div_ready_o, bus.sqrt_ready_o}, 0);
      @(negedge clk);
      chk("tie first div", {bus.eng_strobe_o, bus.eng_is_div_o}, 2'b11);
      wait_done(CH_DIV, "tie div", n);
      chk("tie div quo", {bus.div_Quo_o, bus.div_Rem_o}, {26'h2AAAAA, 26'h2});
      chk("tie gap", bus.eng_strobe_o, 0);
      @(negedge clk);
      chk("tie sqrt next", {bus.eng_strobe_o, bus.eng_is_div_o}, 2'b10);
      wait_done(CH_SQRT, "tie sqrt", n);
      chk("tie sqrt quo", {bus.sqrt_Quo_o, bus.sqrt_Rem_o}, {26'hB50, 26'h700});
      chk("tie div kept", {bus.div_Quo_o, bus.div_Rem_o}, {26'h2AAAAA, 26'h2});

      // Both channels re-strobe on every done: grants must alternate.
      gseq.delete();
      @(negedge clk);
      drive(CH_DIV, 1'b1, 26'h1000000, 26'h0800000);
      drive(CH_SQRT, 1'b1, 26'h0900000, 26'h0);
      nd = 1; ns = 1; dd = 0; sd = 0; bad = 0; n = 0;
      while (n < 2000 && (dd < 10 || sd < 10)) begin
         @(negedge clk);
         n++;
         drive(CH_DIV, 1'b0, 26'h1000000, 26'h0800000);
         drive(CH_SQRT, 1'b0, 26'h0900000, 26'h0);
         if (bus.div_done_o) begin
            dd++;
            if (bus.div_Quo_o !== 26'h1000000) bad++;
            if (nd < 10) begin
               bus.div_strobe_i = 1'b1;
               nd++;
            end
         end
         if (bus.sqrt_done_o) begin
            sd++;
            if (bus.sqrt_Quo_o !== 26'h0600000) bad++;
            if (ns < 10) begin
               bus.sqrt_strobe_i = 1'b1;
               ns++;
            end
         end
      end
      viol = 0;
      for (int i = 1; i < gseq.size(); i++) begin
         if (gseq[i] == gseq[i-1]) viol++;
      end
      chk("rr div count", dd, 10);
      chk("rr sqrt count", sd, 10);
      chk("rr grants", gseq.size(), 20);
      chk("rr first div", gseq.size() > 0 ? gseq[0] : 1'b0, 1);
      chk("rr alternate", viol, 0);
      chk("rr results", bad, 0);

      // Strobe while not ready is dropped.
      snap = div_dones;
      @(negedge clk);
      drive(CH_DIV, 1'b1, 26'h1000000, 26'h0800000);
      @(negedge clk);
      drive(CH_DIV, 1'b1, 26'h1, 26'h3);
      @(negedge clk);
      drive(CH_DIV, 1'b0, '0, '0);
      chk("ign eng N", bus.eng_N_o, 26'h1000000);
      wait_done(CH_DIV, "ign", n);
      chk("ign quo", {bus.div_Quo_o, bus.div_Rem_o}, {26'h1000000, 26'h0});
      repeat (20) @(negedge clk);
      chk("ign one done", div_dones - snap, 1);

      // Engine not ready: request waits, issues one cycle after ready.
      s0 = eng_strobes;
      eng_en = 1'b0;
      drive(CH_SQRT, 1'b1, 26'h0900000, 26'h0);
      @(negedge clk);
      drive(CH_SQRT, 1'b0, '0, '0);
      repeat (5) @(negedge clk);
      chk("hold no strobe", eng_strobes - s0, 0);
      chk("hold pending", {bus.sqrt_ready_o, bus.busy_o}, 2'b00);
      eng_en = 1'b1;
      @(negedge clk);
      chk("hold issue", {bus.eng_strobe_o, bus.eng_is_div_o}, 2'b10);
      wait_done(CH_SQRT, "hold", n);
      chk("hold quo", bus.sqrt_Quo_o, 26'h0600000);

      // Reset in WAIT: back to reset values, no done pulse.
      @(negedge clk);
      drive(CH_DIV, 1'b1, 26'h0C00000, 26'h0800000);
      drive(CH_SQRT, 1'b1, 26'h2, 26'h0);
      @(negedge clk);
      drive(CH_DIV, 1'b0, '0, '0);
      drive(CH_SQRT, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      chk("mid busy", bus.busy_o, 1);
      snap = div_dones + sqrt_dones;
      reset = 1'b1;
      @(negedge clk);
      chk("mid rst res", {bus.div_Quo_o, bus.sqrt_Quo_o,
                          bus.div_Rem_o, bus.sqrt_Rem_o}, 0);
      chk("mid rst eng", {bus.eng_N_o, bus.eng_D_o, bus.eng_strobe_o,
                          bus.eng_is_div_o}, 0);
      chk("mid rst ctl", {bus.div_ready_o, bus.sqrt_ready_o, bus.busy_o,
                          bus.div_done_o, bus.sqrt_done_o}, 5'b11000);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid no done", div_dones + sqrt_dones - snap, 0);
      chk("mid idle", bus.busy_o, 0);
      run_vec(tbl[3], "post");

      // Stray engine done while idle changes nothing.
      snap = div_dones + sqrt_dones;
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray done", div_dones + sqrt_dones - snap, 0);
      chk("stray res", bus.div_Quo_o, 26'h2AAAAA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
